xc20xx_cfg_loader: RTL and testbench

//  Serial configuration loader for the XC20XX fabric: the write side of the CLB/routing config bits.

---
 rtl/xc20xx_cfg_loader_pkg.sv | 23 ++
 rtl/xc20xx_cfg_shreg.sv | 36 +++
 rtl/xc20xx_cfg_loader.sv | 199 +++++++++++++++++++
 tb/tb_xc20xx_cfg_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xc20xx_cfg_loader_pkg.sv
// Shared definitions for the XC20XX serial configuration loader:
// parser state encoding and fixed bitstream field sizes.
package xc20xx_cfg_loader_pkg;

  typedef enum logic [3:0] {
    S_HUNT,
    S_LEN,
    S_LEN_END,
    S_FSTART,
    S_FDATA,
    S_FSTOP,
    S_POST,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [3:0] PREAMBLE_SYNC = 4'b0010;
  localparam int         LEN_W         = 24;
  localparam int         STOP_BITS     = 3;
  localparam int         LEN_END_BITS  = 4;
  localparam int         MIN_ONES      = 4;

endpackage

// File: rtl/xc20xx_cfg_shreg.sv
// MSB-first serial-to-parallel shift register with a bit counter.
// 'last' flags that the next shift completes the word; 'full' that it is complete.
module xc20xx_cfg_shreg #(
  parameter int W = 46
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] data,
  output logic         last,
  output logic         full
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      data <= {data[W-2:0], bit_in};
      if (!full) cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(W - 1));
  assign full = (cnt == CW'(W));

endmodule

// File: rtl/xc20xx_cfg_loader.sv
// XC20XX bit-serial configuration loader: hunts the preamble, loads the length
// count, checks frame framing and hands each verified frame to the frame writer.
module xc20xx_cfg_loader
  import xc20xx_cfg_loader_pkg::*;
#(
  parameter int FRAME_BITS = 46,
  parameter int NUM_FRAMES = 160,
  parameter int ADDR_W     = 8
) (
  input  logic                  k,
  input  logic                  rst_n,
  input  logic                  din,
  input  logic                  din_valid,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic [ADDR_W-1:0]     frame_addr,
  output logic                  frame_we,
  output logic                  done,
  output logic                  err
);

  localparam int FIDX_W = ADDR_W + 1;

  state_t            state, state_d;
  logic [2:0]        ones_q, ones_d;
  logic [1:0]        sync_q, sync_d;
  logic [1:0]        aux_q, aux_d;
  logic [LEN_W-1:0]  bcnt, bcnt_nxt;
  logic [FIDX_W-1:0] fidx;

  logic [LEN_W-1:0]      len_cnt;
  logic                  len_last, len_full;
  logic [FRAME_BITS-1:0] fr_data;
  logic                  fr_last, fr_full;

  logic len_clr, len_sh, fr_clr, fr_sh, bcnt_clr, bcnt_inc, issue;
  logic len_hit, len_eq, last_frame;

  xc20xx_cfg_shreg #(.W(LEN_W)) u_len (
    .clk      (k),
    .rst_n    (rst_n),
    .clr      (len_clr),
    .shift_en (len_sh),
    .bit_in   (din),
    .data     (len_cnt),
    .last     (len_last),
    .full     (len_full)
  );

  xc20xx_cfg_shreg #(.W(FRAME_BITS)) u_frame (
    .clk      (k),
    .rst_n    (rst_n),
    .clr      (fr_clr),
    .shift_en (fr_sh),
    .bit_in   (din),
    .data     (fr_data),
    .last     (fr_last),
    .full     (fr_full)
  );

  assign bcnt_nxt   = (bcnt == '1) ? bcnt : bcnt + LEN_W'(1);
  // Length compare is meaningless until all 24 length bits are in.
  assign len_hit    = len_full && (bcnt_nxt >= len_cnt);
  assign len_eq     = len_full && (bcnt_nxt == len_cnt);
  assign last_frame = (fidx == FIDX_W'(NUM_FRAMES - 1));

  always_ff @(posedge k or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_HUNT;
      ones_q <= '0;
      sync_q <= '0;
      aux_q  <= '0;
    end else begin
      state  <= state_d;
      ones_q <= ones_d;
      sync_q <= sync_d;
      aux_q  <= aux_d;
    end
  end

  always_comb begin
    state_d  = state;
    ones_d   = ones_q;
    sync_d   = sync_q;
    aux_d    = aux_q;
    len_clr  = 1'b0;
    len_sh   = 1'b0;
    fr_clr   = 1'b0;
    fr_sh    = 1'b0;
    bcnt_clr = 1'b0;
    bcnt_inc = 1'b0;
    issue    = 1'b0;
    if (din_valid) begin
      bcnt_inc = state inside {S_LEN, S_LEN_END, S_FSTART, S_FDATA, S_FSTOP, S_POST};
      case (state)
        S_HUNT: begin
          if (sync_q == 2'd0) begin
            if (din) ones_d = (ones_q >= 3'(MIN_ONES)) ? ones_q : ones_q + 3'd1;
            else if (ones_q >= 3'(MIN_ONES)) sync_d = 2'd1;
            else ones_d = 3'd0;
          end else if (din == PREAMBLE_SYNC[2'd3 - sync_q]) begin
            if (sync_q == 2'd3) begin
              state_d  = S_LEN;
              sync_d   = 2'd0;
              ones_d   = 3'd0;
              bcnt_clr = 1'b1;
              len_clr  = 1'b1;
            end else begin
              sync_d = sync_q + 2'd1;
            end
          end else begin
            // A mismatching 1 already starts a new run of ones.
            sync_d = 2'd0;
            ones_d = din ? 3'd1 : 3'd0;
          end
        end
        S_LEN: begin
          len_sh = 1'b1;
          if (len_last) begin
            state_d = S_LEN_END;
            aux_d   = 2'd0;
          end
        end
        S_LEN_END: begin
          if (!din || len_hit) state_d = S_ERROR;
          else if (aux_q == 2'(LEN_END_BITS - 1)) state_d = S_FSTART;
          else aux_d = aux_q + 2'd1;
        end
        S_FSTART: begin
          if (din || len_hit) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_FDATA;
            fr_clr  = 1'b1;
          end
        end
        S_FDATA: begin
          fr_sh = 1'b1;
          if (len_hit) begin
            state_d = S_ERROR;
          end else if (fr_last) begin
            state_d = S_FSTOP;
            aux_d   = 2'd0;
          end
        end
        S_FSTOP: begin
          if (!din || !fr_full) begin
            state_d = S_ERROR;
          end else if (aux_q != 2'(STOP_BITS - 1)) begin
            if (len_hit) state_d = S_ERROR;
            else aux_d = aux_q + 2'd1;
          end else if (last_frame && len_eq) begin
            issue   = 1'b1;
            state_d = S_DONE;
          end else if (len_hit) begin
            state_d = S_ERROR;
          end else begin
            issue   = 1'b1;
            state_d = last_frame ? S_POST : S_FSTART;
          end
        end
        S_POST: begin
          if (len_hit) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge k or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else if (bcnt_clr) begin
      bcnt <= '0;
    end else if (bcnt_inc) begin
      bcnt <= bcnt_nxt;
    end
  end

  // Frame write port: one pulse per verified frame, index stops at NUM_FRAMES.
  always_ff @(posedge k or negedge rst_n) begin
    if (!rst_n) begin
      frame_we   <= 1'b0;
      frame_addr <= '0;
      frame_data <= '0;
      fidx       <= '0;
    end else begin
      frame_we <= issue;
      if (issue) begin
        frame_addr <= fidx[ADDR_W-1:0];
        frame_data <= fr_data;
        fidx       <= fidx + FIDX_W'(1);
      end
    end
  end

  assign done = (state == S_DONE);
  assign err  = (state == S_ERROR);

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Directed bench for xc20xx_cfg_loader with 4-bit frames and two frames per device.
module tb_xc20xx_cfg_loader;

  logic       k = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic [3:0] frame_data;
  logic [1:0] frame_addr;
  logic       frame_we;
  logic       done;
  logic       err;

  int total = 0;
  int bad = 0;

  typedef struct {
    int addr;
    int data;
    int at;
  } wr_t;

  wr_t  wrs[$];
  logic stream[$];
  int   sent_bits = 0;
  int   err_bit = -1;
  int   done_bit = -1;
  int   we_novld = 0;
  int   both_cnt = 0;
  logic vld_edge = 1'b0;

  xc20xx_cfg_loader #(
    .FRAME_BITS (4),
    .NUM_FRAMES (2),
    .ADDR_W     (2)
  ) dut (
    .k          (k),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_data (frame_data),
    .frame_addr (frame_addr),
    .frame_we   (frame_we),
    .done       (done),
    .err        (err)
  );

  always #5 k = ~k;

  always @(posedge k) vld_edge = din_valid;

  // Observe outputs on the falling edge, half a cycle from the active edge.
  always @(negedge k) begin
    if (rst_n) begin
      if (frame_we) begin
        wrs.push_back('{addr: int'(frame_addr), data: int'(frame_data), at: sent_bits});
        if (!vld_edge) we_novld++;
      end
      if (err && err_bit < 0) err_bit = sent_bits;
      if (done && done_bit < 0) done_bit = sent_bits;
      if (err && done) both_cnt++;
    end
  end

  function automatic wr_t get_wr(int i);
    wr_t r;
    r.addr = -1;
    r.data = -1;
    r.at   = -1;
    if (i < wrs.size()) r = wrs[i];
    return r;
  endfunction

  task automatic clear_log();
    wrs.delete();
    sent_bits = 0;
    err_bit   = -1;
    done_bit  = -1;
    we_novld  = 0;
    both_cnt  = 0;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    din       = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge k);
    #1 rst_n = 1'b1;
    clear_log();
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) stream.push_back(v[i]);
  endtask

  task automatic build_stream(input logic [7:0] f1, input logic [23:0] len, input bit garbage);
    stream.delete();
    if (garbage) push_bits(32'hD2, 8);
    push_bits(32'hFF, 8);
    push_bits(32'h2, 4);
    push_bits(32'(len), 24);
    push_bits(32'hF, 4);
    push_bits(32'h57, 8);
    push_bits(32'(f1), 8);
    push_bits(32'hF, 4);
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      din_valid = 1'b0;
      din       = 1'($urandom);
      @(posedge k);
      #1;
    end
    din_valid = 1'b1;
    din       = b;
    @(posedge k);
    sent_bits++;
    #1;
  endtask

  task automatic send_stream(input int gapmode, input int nbits);
    int n;
    n = (nbits < 0) ? stream.size() : nbits;
    for (int i = 0; i < n; i++) send_bit(stream[i], gapmode ? int'($urandom_range(0, 1)) : 0);
    din_valid = 1'b0;
    repeat (3) @(posedge k);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    @(posedge k);
    #1;
    if (frame_we !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", frame_we); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
    total++;
    if (frame_addr !== 2'd0) begin bad++; $display("FAIL reset_addr got %0d want 0", frame_addr); end
    total++;
    if (frame_data !== 4'h0) begin bad++; $display("FAIL reset_data got %h want 0", frame_data); end
    total++;
    #1 rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_good_stream(input string tag, input int gapmode, input bit garbage);
    int   off;
    wr_t  w0, w1;
    off = garbage ? 8 : 0;
    do_reset();
    build_stream(8'h37, 24'd48, garbage);
    send_stream(gapmode, -1);
    w0 = get_wr(0);
    w1 = get_wr(1);
    if (wrs.size() != 2) begin bad++; $display("FAIL %s we_count got %0d want 2", tag, wrs.size()); end
    total++;
    if (w0.addr != 0 || w0.data != 'hA) begin
      bad++; $display("FAIL %s write0 got addr=%0d data=%h want addr=0 data=a", tag, w0.addr, w0.data);
    end
    total++;
    if (w1.addr != 1 || w1.data != 'h6) begin
      bad++; $display("FAIL %s write1 got addr=%0d data=%h want addr=1 data=6", tag, w1.addr, w1.data);
    end
    total++;
    if (w0.at != off + 48) begin bad++; $display("FAIL %s we0_latency got bit %0d want %0d", tag, w0.at, off + 48); end
    total++;
    if (w1.at != off + 56) begin bad++; $display("FAIL %s we1_latency got bit %0d want %0d", tag, w1.at, off + 56); end
    total++;
    if (done_bit != off + 60) begin bad++; $display("FAIL %s done_at got bit %0d want %0d", tag, done_bit, off + 60); end
    total++;
    if (err_bit != -1) begin bad++; $display("FAIL %s err got bit %0d want never", tag, err_bit); end
    total++;
    if (we_novld != 0) begin bad++; $display("FAIL %s we_without_valid got %0d want 0", tag, we_novld); end
    total++;
  endtask

  task automatic test_stop_err();
    wr_t w0;
    do_reset();
    build_stream(8'h35, 24'd48, 1'b0);
    send_stream(0, -1);
    w0 = get_wr(0);
    if (wrs.size() != 1) begin bad++; $display("FAIL stoperr we_count got %0d want 1", wrs.size()); end
    total++;
    if (w0.addr != 0 || w0.data != 'hA) begin
      bad++; $display("FAIL stoperr write0 got addr=%0d data=%h want addr=0 data=a", w0.addr, w0.data);
    end
    total++;
    if (err_bit != 55) begin bad++; $display("FAIL stoperr err_at got bit %0d want 55", err_bit); end
    total++;
    if (done_bit != -1) begin bad++; $display("FAIL stoperr done got bit %0d want never", done_bit); end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL stoperr err_sticky got %b want 1", err); end
    total++;
    if (both_cnt != 0) begin bad++; $display("FAIL stoperr err_and_done got %0d want 0", both_cnt); end
    total++;
  endtask

  task automatic test_short_len();
    do_reset();
    build_stream(8'h37, 24'd30, 1'b0);
    send_stream(0, -1);
    if (wrs.size() != 0) begin bad++; $display("FAIL shortlen we_count got %0d want 0", wrs.size()); end
    total++;
    if (err_bit != 42) begin bad++; $display("FAIL shortlen err_at got bit %0d want 42", err_bit); end
    total++;
    if (done_bit != -1) begin bad++; $display("FAIL shortlen done got bit %0d want never", done_bit); end
    total++;
  endtask

  task automatic test_reset_mid();
    logic pre_done;
    wr_t  w0;
    // Left in DONE by the previous scenario: drop reset between clock edges.
    @(posedge k);
    pre_done = done;
    #2 rst_n = 1'b0;
    #1;
    if (pre_done !== 1'b1) begin bad++; $display("FAIL rstmid pre_done got %b want 1", pre_done); end
    total++;
    if (done !== 1'b0 || err !== 1'b0 || frame_we !== 1'b0) begin
      bad++; $display("FAIL rstmid async_flags got done=%b err=%b we=%b want 0 0 0", done, err, frame_we);
    end
    total++;
    if (frame_addr !== 2'd0 || frame_data !== 4'h0) begin
      bad++; $display("FAIL rstmid async_bus got addr=%0d data=%h want 0 0", frame_addr, frame_data);
    end
    total++;
    @(posedge k);
    #1 rst_n = 1'b1;
    clear_log();
    build_stream(8'h37, 24'd48, 1'b0);
    send_stream(0, 44);
    rst_n = 1'b0;
    #1;
    if (wrs.size() != 0) begin bad++; $display("FAIL rstmid partial_we got %0d want 0", wrs.size()); end
    total++;
    @(posedge k);
    #1 rst_n = 1'b1;
    clear_log();
    send_stream(0, -1);
    w0 = get_wr(0);
    if (w0.addr != 0 || w0.data != 'hA) begin
      bad++; $display("FAIL rstmid reload_write0 got addr=%0d data=%h want addr=0 data=a", w0.addr, w0.data);
    end
    total++;
    if (wrs.size() != 2) begin bad++; $display("FAIL rstmid reload_count got %0d want 2", wrs.size()); end
    total++;
    if (done_bit != 60) begin bad++; $display("FAIL rstmid reload_done got bit %0d want 60", done_bit); end
    total++;
  endtask

  initial begin
    test_reset();
    test_good_stream("good", 0, 1'b0);
    test_good_stream("toggle", 1, 1'b0);
    test_stop_err();
    test_short_len();
    test_good_stream("garbage", 0, 1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
